blowfish128_key_loader: RTL and testbench
=========================================

Name: blowfish128_key_loader

Overview:
- Initiator-side front end for the Blowfish-128 P-array key schedule generator.
- Accepts the user key as a stream of 32-bit words over a valid/ready handshake, and packs them into the eight 64-bit key buses plus a word-count key_length.
- Issues a one-cycle Enable to the key schedule generator, waits for its skey_ready rising edge, then reports key_valid to the host.
- Sits between the host/register interface and the key schedule generator.

Parameters:
- MAX_WORDS, 14: maximum accepted key words (14 x 32 = 448 bits); legal range 1..15.
- TIMEOUT_CYCLES, 15: WAIT-state cycle budget before err_timeout (only used with the optional feature).

Ports:
- Clk  in  1  clock; all logic on rising edge.
- RstN  in  1  asynchronous active-low reset.
- kw_data  in  32  key word.
- kw_valid  in  1  kw_data valid.
- kw_last  in  1  final key word of this key.
- kw_encrypt  in  1  direction flag, sampled with the first word of a key.
- kw_ready  out  1  loader can accept a word.
- key0..key7  out  64 each  packed key; word n drives bits [n*32 +: 32] of {key7,...,key0}.
- key_length  out  4  number of words in the loaded key (1..MAX_WORDS).
- Encrypt  out  1  latched kw_encrypt.
- Enable  out  1  single-cycle start pulse to the key schedule generator.
- skey_ready  in  1  completion flag from the key schedule generator.
- busy  out  1  high in LOAD, REQ and WAIT.
- key_valid  out  1  schedule for the current key is complete.
- err_len  out  1  sticky; the last key overran MAX_WORDS.
- err_timeout  out  1  sticky; no skey_ready edge within budget (optional feature only).

Behaviour:
- Reset values: all key regs, key_length, Encrypt, Enable, busy, key_valid, err_len, err_timeout = 0; word count = 0; state = IDLE. Because kw_ready is combinational from state, it reads 1 during reset.
- kw_ready = 1 in IDLE and LOAD, and also in DRAIN. It is 0 in REQ and WAIT, so the key buses are frozen while the generator reads them.
- States are IDLE, LOAD, DRAIN, REQ, WAIT. A transfer is accepted when kw_valid & kw_ready.
- IDLE, on transfer:
  - Clear all key words to 0, then write kw_data into word 0.
  - Latch Encrypt <= kw_encrypt; set count = 1.
  - Clear key_valid, err_len and err_timeout.
  - Go to REQ if kw_last, else LOAD.
- LOAD, on transfer:
  - Write word[count]; count + 1.
  - If kw_last, set key_length = new count and go to REQ.
  - If the transfer arrives with count == MAX_WORDS and not kw_last, do not write it; set err_len = 1 and go to DRAIN.
  - A kw_last word arriving at count == MAX_WORDS is also an overrun: set err_len, return to IDLE, no Enable.
- Single-word key (kw_last in IDLE): key_length = 1.
- DRAIN: absorb and discard words until kw_last, then go to IDLE. No Enable is issued, key_valid stays 0, and the key regs keep their partial contents.
- REQ: Enable = 1 for exactly this cycle; go to WAIT. The skey_ready history register is cleared to 0 on entry to WAIT.
- WAIT:
  - Register skey_ready into ready_d every cycle.
  - A rise (skey_ready & !ready_d) sets key_valid = 1 and returns to IDLE.
  - A stale high skey_ready from a previous key is never taken as completion: ready_d starts at 0 and the generator drops skey_ready on the Enable edge. Completion therefore requires the generator to drop skey_ready and raise it again.
- Latency: with the last word accepted at edge N, Enable is high in cycle N..N+1 and key_valid rises at edge N+5 (the generator takes 3 cycles).
- key_valid holds until the next accepted first word.
- RstN asserted mid-operation returns everything to reset values immediately. No Enable is generated afterwards.

Optional Feature:
- Macro: BF_KEYLOAD_TIMEOUT_EN.
- Defined: a WAIT-state counter loads 0 on entry and increments each cycle. On reaching TIMEOUT_CYCLES without a rise, set err_timeout = 1, leave key_valid = 0 and go to IDLE.
- Undefined: no counter is built, err_timeout is tied to 0, and WAIT blocks indefinitely until a rise.

Test Plan:
- Reset, then 4 words 0x11111111, 0x22222222, 0x33333333, 0x44444444 (last on 4th), encrypt=1: key0 = 0x2222222211111111, key1 = 0x4444444433333333, key2..key7 = 0, key_length = 4, Encrypt = 1, one Enable pulse, key_valid at N+5 with a cycle-accurate generator model.
- 1-word key 0xDEADBEEF, encrypt=0: key0 = 0x00000000DEADBEEF, key_length = 1, Encrypt = 0. Then reload 2 words and check key0 upper/lower updated and the others cleared.
- 16 words with no kw_last until the 16th: err_len = 1, kw_ready stays 1 through DRAIN, no Enable, key_valid = 0, and the next key clears err_len.
- Hold skey_ready = 1 at Enable, then drop and raise it after 6 cycles: key_valid only after the re-rise; kw_valid driven in REQ/WAIT is not accepted.
- With BF_KEYLOAD_TIMEOUT_EN, a generator that never raises skey_ready gives err_timeout = 1 exactly TIMEOUT_CYCLES = 15 cycles after WAIT entry, then IDLE. Without the macro, busy stays 1.
- Assert RstN = 0 during WAIT: all outputs read 0 on the next edge check, and no further Enable appears after release.

Source files
------------

// File: rtl/blowfish128_key_loader_if.sv
// Key-word stream between the host/register block and the Blowfish-128 key loader.
interface blowfish128_key_loader_if;
  logic [31:0] kw_data;
  logic        kw_valid;
  logic        kw_last;
  logic        kw_encrypt;
  logic        kw_ready;

  modport master (output kw_data, kw_valid, kw_last, kw_encrypt, input kw_ready);
  modport slave  (input kw_data, kw_valid, kw_last, kw_encrypt, output kw_ready);
endinterface

// File: rtl/blowfish128_key_loader.sv
// Packs a streamed 32-bit user key into eight 64-bit buses, kicks the P-array schedule
// generator and reports completion. Optional WAIT timeout: BF_KEYLOAD_TIMEOUT_EN.
module blowfish128_key_loader #(
  parameter int MAX_WORDS      = 14,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                      Clk,
  input  logic                      RstN,
  blowfish128_key_loader_if.slave   kw,
  output logic [63:0]               key0,
  output logic [63:0]               key1,
  output logic [63:0]               key2,
  output logic [63:0]               key3,
  output logic [63:0]               key4,
  output logic [63:0]               key5,
  output logic [63:0]               key6,
  output logic [63:0]               key7,
  output logic [3:0]                key_length,
  output logic                      Encrypt,
  output logic                      Enable,
  input  logic                      skey_ready,
  output logic                      busy,
  output logic                      key_valid,
  output logic                      err_len,
  output logic                      err_timeout
);

  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, REQ, WAIT} state_t;

  localparam logic [3:0] MAX_W = 4'(MAX_WORDS);

  state_t            state, state_nxt;
  logic [15:0][31:0] key_w;
  logic [3:0]        cnt;
  logic              ready_d;
  logic              xfer, rise, tmo;

  assign kw.kw_ready = (state == IDLE) || (state == LOAD) || (state == DRAIN);
  assign xfer        = kw.kw_valid & kw.kw_ready;
  assign rise        = skey_ready & ~ready_d;
  assign Enable      = (state == REQ);
  assign busy        = (state == LOAD) || (state == REQ) || (state == WAIT);

  assign key0 = key_w[1:0];
  assign key1 = key_w[3:2];
  assign key2 = key_w[5:4];
  assign key3 = key_w[7:6];
  assign key4 = key_w[9:8];
  assign key5 = key_w[11:10];
  assign key6 = key_w[13:12];
  assign key7 = key_w[15:14];

`ifdef BF_KEYLOAD_TIMEOUT_EN
  localparam int            TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tcnt;

  assign tmo = (state == WAIT) && !rise && (tcnt == TLAST);

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      tcnt        <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (state == REQ)       tcnt <= '0;
      else if (state == WAIT) tcnt <= tcnt + 1'b1;
      if (state == IDLE && xfer) err_timeout <= 1'b0;
      else if (tmo)              err_timeout <= 1'b1;
    end
  end
`else
  assign tmo         = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (xfer) state_nxt = kw.kw_last ? REQ : LOAD;
      LOAD:  if (xfer) begin
               // a word arriving with the buffer full is an overrun, last or not
               if (cnt == MAX_W)     state_nxt = kw.kw_last ? IDLE : DRAIN;
               else if (kw.kw_last)  state_nxt = REQ;
             end
      DRAIN: if (xfer && kw.kw_last) state_nxt = IDLE;
      REQ:   state_nxt = WAIT;
      WAIT:  if (rise || tmo) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      key_w      <= '0;
      cnt        <= '0;
      key_length <= '0;
      Encrypt    <= 1'b0;
      key_valid  <= 1'b0;
      err_len    <= 1'b0;
      ready_d    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (xfer) begin
          key_w     <= {{15{32'h0}}, kw.kw_data};
          Encrypt   <= kw.kw_encrypt;
          cnt       <= 4'd1;
          key_valid <= 1'b0;
          err_len   <= 1'b0;
          if (kw.kw_last) key_length <= 4'd1;
        end
        LOAD: if (xfer) begin
          if (cnt == MAX_W) begin
            err_len <= 1'b1;
          end else begin
            key_w[cnt] <= kw.kw_data;
            cnt        <= cnt + 4'd1;
            if (kw.kw_last) key_length <= cnt + 4'd1;
          end
        end
        // history starts low so a level left high by the previous key is not a rise
        REQ:  ready_d <= 1'b0;
        WAIT: begin
          ready_d <= skey_ready;
          if (rise) key_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_blowfish128_key_loader.sv
// Directed bench for blowfish128_key_loader: key-stream driver, 3+ cycle schedule
// generator model, per-cycle compare against an expected-output model plus literal pins.
module tb_blowfish128_key_loader;
  localparam int MAXW = 14;
  localparam int TMO  = 15;

  logic        Clk  = 1'b0;
  logic        RstN = 1'b0;
  logic [63:0] key0, key1, key2, key3, key4, key5, key6, key7;
  logic [3:0]  key_length;
  logic        Encrypt, Enable, busy, key_valid, err_len, err_timeout;
  logic        skey_ready = 1'b0;

  blowfish128_key_loader_if kw();

  blowfish128_key_loader #(.MAX_WORDS(MAXW), .TIMEOUT_CYCLES(TMO)) dut (
    .Clk(Clk), .RstN(RstN), .kw(kw),
    .key0(key0), .key1(key1), .key2(key2), .key3(key3),
    .key4(key4), .key5(key5), .key6(key6), .key7(key7),
    .key_length(key_length), .Encrypt(Encrypt), .Enable(Enable),
    .skey_ready(skey_ready), .busy(busy), .key_valid(key_valid),
    .err_len(err_len), .err_timeout(err_timeout)
  );

  always #5 Clk = ~Clk;

  // expected-output model, written only by the driver
  logic [31:0] exp_w [16];
  logic [3:0]  exp_len;
  logic        exp_enc, exp_en, exp_busy, exp_rdy, exp_kv, exp_el, exp_et;
  logic        chk_en;
  logic        lit_on;
  logic [63:0] lit_k0, lit_k1;
  logic [3:0]  lit_len;
  logic        lit_el;
  int          lat_exp, last_cyc, gen_dly;
  logic [31:0] wbuf [16];

  // schedule generator: drops skey_ready on Enable, raises it gen_dly edges later
  int   cyc = 0, en_cyc = 0;
  logic armed = 1'b0;
  always @(posedge Clk) begin
    cyc <= cyc + 1;
    if (Enable) begin
      skey_ready <= 1'b0;
      armed      <= (gen_dly > 0);
      en_cyc     <= cyc;
    end else if (armed && cyc == en_cyc + gen_dly) begin
      skey_ready <= 1'b1;
      armed      <= 1'b0;
    end
  end

  logic [63:0] dk [8];
  always_comb begin
    dk[0] = key0; dk[1] = key1; dk[2] = key2; dk[3] = key3;
    dk[4] = key4; dk[5] = key5; dk[6] = key6; dk[7] = key7;
  end

  int   errors = 0, checks = 0;
  logic kv_prev = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge Clk) begin
    if (chk_en) begin
      for (int i = 0; i < 8; i++)
        chk($sformatf("key%0d", i), dk[i], {exp_w[2*i+1], exp_w[2*i]});
      chk("key_length",  key_length,  exp_len);
      chk("Encrypt",     Encrypt,     exp_enc);
      chk("Enable",      Enable,      exp_en);
      chk("busy",        busy,        exp_busy);
      chk("kw_ready",    kw.kw_ready, exp_rdy);
      chk("key_valid",   key_valid,   exp_kv);
      chk("err_len",     err_len,     exp_el);
      chk("err_timeout", err_timeout, exp_et);
      if (lit_on) begin
        chk("pin_key0",    key0,       lit_k0);
        chk("pin_key1",    key1,       lit_k1);
        chk("pin_len",     key_length, lit_len);
        chk("pin_err_len", err_len,    lit_el);
      end
      if (key_valid && !kv_prev && lat_exp >= 0)
        chk("latency", 64'(cyc - last_cyc), 64'(lat_exp));
    end
    kv_prev <= key_valid;
  end

  task automatic reset_model();
    for (int j = 0; j < 16; j++) exp_w[j] = '0;
    exp_len = '0; exp_enc = 0; exp_en = 0; exp_busy = 0;
    exp_rdy = 1;  exp_kv = 0;  exp_el = 0; exp_et = 0;
  endtask

  task automatic pin(input logic [63:0] k0, input logic [63:0] k1, input logic [3:0] len, input logic el);
    lit_k0 = k0; lit_k1 = k1; lit_len = len; lit_el = el; lit_on = 1;
    @(posedge Clk); #1;
    lit_on = 0;
  endtask

  // d>0: generator completes d edges after Enable; d==0: never completes; d<0: return after Enable
  task automatic send_key(input int n, input logic enc, input int d, input logic junk);
    gen_dly = d;
    for (int i = 0; i < n; i++) begin
      kw.kw_data = wbuf[i]; kw.kw_valid = 1; kw.kw_last = (i == n-1); kw.kw_encrypt = enc;
      @(posedge Clk); #1;
      if (i == 0) begin
        for (int j = 0; j < 16; j++) exp_w[j] = '0;
        exp_w[0] = wbuf[0]; exp_enc = enc; exp_kv = 0; exp_el = 0; exp_et = 0;
      end else if (i < MAXW) exp_w[i] = wbuf[i];
      else if (i == MAXW)    exp_el = 1;
      exp_busy = (i < MAXW);
      if (i == n-1) begin
        last_cyc = cyc;
        if (n <= MAXW) begin
          exp_len = 4'(n); exp_busy = 1; exp_rdy = 0; exp_en = 1;
        end else exp_busy = 0;
      end
      kw.kw_valid = 0; kw.kw_last = 0;
    end
    if (n <= MAXW) begin
      if (junk) begin kw.kw_data = 32'hBAD0BAD0; kw.kw_valid = 1; kw.kw_last = 1; end
      @(posedge Clk); #1;
      exp_en = 0;
      if (d > 0) begin
        repeat (d) @(posedge Clk);
        #1; kw.kw_valid = 0; kw.kw_last = 0;
        @(posedge Clk); #1;
        exp_kv = 1; exp_busy = 0; exp_rdy = 1;
      end else if (d == 0) begin
`ifdef BF_KEYLOAD_TIMEOUT_EN
        repeat (TMO) @(posedge Clk);
        #1; exp_et = 1; exp_busy = 0; exp_rdy = 1;
`endif
      end
    end
  endtask

  initial begin
    kw.kw_data = '0; kw.kw_valid = 0; kw.kw_last = 0; kw.kw_encrypt = 0;
    gen_dly = 0; lat_exp = -1; last_cyc = 0; lit_on = 0; chk_en = 0;
    lit_k0 = '0; lit_k1 = '0; lit_len = '0; lit_el = 0;
    for (int j = 0; j < 16; j++) wbuf[j] = '0;
    reset_model();
    repeat (2) @(posedge Clk);
    #1 chk_en = 1;
    @(posedge Clk); #1 RstN = 1;
    @(posedge Clk); #1;

    // four-word key, encrypt, 3-cycle generator
    wbuf[0] = 32'h11111111; wbuf[1] = 32'h22222222; wbuf[2] = 32'h33333333; wbuf[3] = 32'h44444444;
    lat_exp = 5;
    send_key(4, 1'b1, 3, 1'b0);
    lat_exp = -1;
    pin(64'h2222222211111111, 64'h4444444433333333, 4'd4, 1'b0);

    // single-word key, then a two-word reload
    wbuf[0] = 32'hDEADBEEF;
    send_key(1, 1'b0, 3, 1'b0);
    pin(64'h00000000DEADBEEF, 64'h0, 4'd1, 1'b0);
    wbuf[0] = 32'hAAAA0001; wbuf[1] = 32'hBBBB0002;
    send_key(2, 1'b1, 3, 1'b0);
    pin(64'hBBBB0002AAAA0001, 64'h0, 4'd2, 1'b0);

    // sixteen words: overrun, drain, no Enable
    for (int j = 0; j < 16; j++) wbuf[j] = 32'hC0DE0000 + j;
    send_key(16, 1'b1, 3, 1'b0);
    repeat (2) @(posedge Clk); #1;
    pin(64'hC0DE0001C0DE0000, 64'hC0DE0003C0DE0002, 4'd2, 1'b1);

    // kw_last exactly on the overrun word
    send_key(15, 1'b0, 3, 1'b0);
    repeat (2) @(posedge Clk); #1;
    pin(64'hC0DE0001C0DE0000, 64'hC0DE0003C0DE0002, 4'd2, 1'b1);

    // stale-high skey_ready, slow generator, words offered in REQ/WAIT are refused
    wbuf[0] = 32'h01234567; wbuf[1] = 32'h89ABCDEF; wbuf[2] = 32'h0F0F0F0F;
    lat_exp = 8;
    send_key(3, 1'b1, 6, 1'b1);
    lat_exp = -1;
    pin(64'h89ABCDEF01234567, 64'h000000000F0F0F0F, 4'd3, 1'b0);

    // reset while waiting on the generator
    wbuf[0] = 32'h55555555; wbuf[1] = 32'h66666666;
    send_key(2, 1'b1, -1, 1'b0);
    repeat (3) @(posedge Clk);
    #1 RstN = 0;
    reset_model();
    repeat (2) @(posedge Clk);
    #1 RstN = 1;
    repeat (10) @(posedge Clk);
    #1;

    // generator that never completes
    wbuf[0] = 32'h77777777; wbuf[1] = 32'h88888888; wbuf[2] = 32'h99999999;
    send_key(3, 1'b0, 0, 1'b0);
    repeat (20) @(posedge Clk);
    #1;

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
